// File: rtl/sarray_tinst_seq.sv
// Tile-instruction sequencer for the systolic array.
// Loads (TMMA/PRELOADA/PRELOADC) issue AR bursts with a bounded number of
// outstanding reads and forward returned beats to the shift-register front end.
// STOREC drains array bottom-out beats onto the AW channel.
module sarray_tinst_seq #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned MAX_BEATS  = 64,
  parameter int unsigned STRIDE     = 256,
  parameter int unsigned MAX_OUTSTD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // instruction port
  input  logic                          tinst_valid_i,
  output logic                          tinst_ready_o,
  input  logic [1:0]                    tinst_type_i,
  input  logic [ADDR_W-1:0]             tinst_addr_i,
  input  logic [$clog2(MAX_BEATS)-1:0]  tinst_len_i,
  // read address channel
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [ADDR_W-1:0]             ar_addr_o,
  // read data channel
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  input  logic [DATA_W-1:0]             r_data_i,
  // forwarded load beats
  output logic                          beat_valid_o,
  output logic [1:0]                    beat_type_o,
  output logic [$clog2(MAX_BEATS)-1:0]  beat_cnt_o,
  output logic [DATA_W-1:0]             beat_data_o,
  output logic                          abuf_id_o,
  // array bottom-out data
  input  logic                          store_valid_i,
  output logic                          store_ready_o,
  input  logic [DATA_W-1:0]             store_data_i,
  // write channel
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [ADDR_W-1:0]             aw_addr_o,
  output logic [DATA_W-1:0]             aw_data_o,
  // status
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTD + 1);

  localparam logic [1:0] T_TMMA     = 2'd0;
  localparam logic [1:0] T_PRELOADA = 2'd1;
  localparam logic [1:0] T_PRELOADC = 2'd2;
  localparam logic [1:0] T_STOREC   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         typ;
  logic [ADDR_W-1:0]  base;
  logic [CNT_W-1:0]   len;
  logic [CNT_W:0]     ar_cnt;   // one extra bit so len=MAX_BEATS-1 cannot alias
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt;
  logic [OUT_W-1:0]   outstd;
  logic [OUT_W-1:0]   outstd_nxt;
  logic               abuf_id;
  logic               done;

  logic is_idle;
  logic is_load;
  logic is_store;
  logic ar_more;
  logic ar_room;
  logic tinst_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic r_last;
  logic w_last;

  // State decode and handshake qualifiers
  assign is_idle  = (state == S_IDLE);
  assign is_load  = (state == S_LOAD);
  assign is_store = (state == S_STORE);

  assign ar_more  = (ar_cnt <= {1'b0, len});
  assign ar_room  = (outstd < OUT_W'(MAX_OUTSTD));

  assign tinst_hs = is_idle & tinst_valid_i;
  assign ar_hs    = ar_valid_o & ar_ready_i;
  assign r_hs     = r_valid_i & r_ready_o;
  assign aw_hs    = aw_valid_o & aw_ready_i;
  assign r_last   = r_hs & (r_cnt == len);
  assign w_last   = aw_hs & (w_cnt == len);

  // Instruction port and load-side channel outputs
  assign tinst_ready_o = is_idle;
  assign ar_valid_o    = is_load & ar_more & ar_room;
  assign ar_addr_o     = base + ADDR_W'(ar_cnt) * ADDR_W'(STRIDE);
  assign r_ready_o     = is_load;

  // Beats are forwarded in the same cycle they are accepted from R
  assign beat_valid_o  = r_hs;
  assign beat_type_o   = typ;
  assign beat_cnt_o    = r_cnt;
  assign beat_data_o   = r_data_i;
  assign abuf_id_o     = abuf_id;

  // Store path passes bottom-out beats straight through to AW while in STORE
  assign aw_valid_o    = is_store & store_valid_i;
  assign store_ready_o = is_store & aw_ready_i;
  assign aw_data_o     = store_data_i;
  assign aw_addr_o     = base + ADDR_W'(w_cnt) * ADDR_W'(STRIDE);

  assign busy_o        = ~is_idle;
  assign done_o        = done;

  // Outstanding-read count: simultaneous AR and R handshakes cancel
  always_comb begin
    outstd_nxt = outstd;
    case ({ar_hs, r_hs})
      2'b10:   outstd_nxt = outstd + OUT_W'(1);
      2'b01:   outstd_nxt = outstd - OUT_W'(1);
      default: outstd_nxt = outstd;
    endcase
  end

  // Sequencer FSM with instruction latch, beat counters and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      typ     <= T_TMMA;
      base    <= '0;
      len     <= '0;
      ar_cnt  <= '0;
      r_cnt   <= '0;
      w_cnt   <= '0;
      outstd  <= '0;
      abuf_id <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tinst_hs) begin
            typ    <= tinst_type_i;
            base   <= tinst_addr_i;
            len    <= tinst_len_i;
            ar_cnt <= '0;
            r_cnt  <= '0;
            w_cnt  <= '0;
            outstd <= '0;
            if (tinst_type_i == T_PRELOADA) begin
              abuf_id <= ~abuf_id;
            end
            if (tinst_type_i == T_STOREC) begin
              state <= S_STORE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (ar_hs) begin
            ar_cnt <= ar_cnt + (CNT_W + 1)'(1);
          end
          if (r_hs) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          outstd <= outstd_nxt;
          if (r_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_STORE: begin
          if (aw_hs) begin
            w_cnt <= w_cnt + CNT_W'(1);
          end
          if (w_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // PRELOADC shares the load datapath; the type is only carried on beat_type_o
  logic unused_types;
  assign unused_types = (T_PRELOADC == typ);

endmodule

// File: tb/tb_sarray_tinst_seq.sv
// Scoreboard bench for sarray_tinst_seq: stimulus pushes expected AR/beat/AW
// transactions; an independent monitor pops and compares as the DUT presents them.
module tb_sarray_tinst_seq;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              tinst_valid;
  logic              tinst_ready;
  logic [1:0]        tinst_type;
  logic [ADDR_W-1:0] tinst_addr;
  logic [CNT_W-1:0]  tinst_len;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              beat_valid;
  logic [1:0]        beat_type;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] beat_data;
  logic              abuf_id;
  logic              store_valid;
  logic              store_ready;
  logic [DATA_W-1:0] store_data;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] aw_data;
  logic              busy;
  logic              done;

  sarray_tinst_seq #(
    .ADDR_W(64), .DATA_W(256), .MAX_BEATS(64), .STRIDE(256), .MAX_OUTSTD(4)
  ) dut (
    .clk(clk), .rst(rst),
    .tinst_valid_i(tinst_valid), .tinst_ready_o(tinst_ready),
    .tinst_type_i(tinst_type), .tinst_addr_i(tinst_addr), .tinst_len_i(tinst_len),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
    .beat_valid_o(beat_valid), .beat_type_o(beat_type), .beat_cnt_o(beat_cnt),
    .beat_data_o(beat_data), .abuf_id_o(abuf_id),
    .store_valid_i(store_valid), .store_ready_o(store_ready), .store_data_i(store_data),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_data_o(aw_data),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        typ;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } aw_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int ar_hs_cnt = 0;
  int beat_seen = 0;
  int exp_done = 0;

  logic [ADDR_W-1:0] exp_ar[$];
  beat_t             exp_beat[$];
  aw_t               exp_aw[$];
  logic [ADDR_W-1:0] pend[$];
  logic [DATA_W-1:0] st_q[$];

  bit r_en = 1'b0;
  bit ar_rdy_en = 1'b1;
  bit ar_tog = 1'b0;
  bit aw_tog = 1'b0;
  bit force_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected transaction at cycle %0d", name, cyc);
  endtask

  // Memory/array-side responder: drives inputs on negedge, records handshakes
  initial begin
    ar_ready = 1'b1; aw_ready = 1'b1; r_valid = 1'b0; r_data = '0;
    store_valid = 1'b0; store_data = '0;
    forever begin
      @(negedge clk);
      ar_ready    = ar_tog ? ~ar_ready : ar_rdy_en;
      aw_ready    = aw_tog ? ~aw_ready : 1'b1;
      r_valid     = force_rv || (r_en && pend.size() > 0);
      r_data      = (pend.size() > 0) ? {4{pend[0]}} : '1;
      store_valid = (st_q.size() > 0);
      store_data  = (st_q.size() > 0) ? st_q[0] : '0;
      #1;
      if (r_valid && r_ready && pend.size() > 0) void'(pend.pop_front());
      if (ar_valid && ar_ready) begin
        pend.push_back(ar_addr);
        ar_hs_cnt++;
      end
      if (aw_valid && aw_ready && st_q.size() > 0) void'(st_q.pop_front());
    end
  end

  // Monitor: compares every presented transaction against the expected queues
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (ar_valid && ar_ready) begin
        if (exp_ar.size() == 0) spurious("ar_spurious");
        else chk("ar_addr", ar_addr, exp_ar.pop_front());
      end
      if (beat_valid) begin
        beat_t b;
        beat_seen++;
        last_hs_cyc = cyc;
        if (exp_beat.size() == 0) spurious("beat_spurious");
        else begin
          b = exp_beat.pop_front();
          chk("beat_cnt", beat_cnt, b.cnt);
          chk("beat_type", beat_type, b.typ);
          chk("beat_data", beat_data, b.data);
        end
      end
      if (aw_valid && aw_ready) begin
        aw_t w;
        last_hs_cyc = cyc;
        if (exp_aw.size() == 0) spurious("aw_spurious");
        else begin
          w = exp_aw.pop_front();
          chk("aw_addr", aw_addr, w.addr);
          chk("aw_data", aw_data, w.data);
        end
      end
      if (done === 1'b1) begin
        if (exp_done == 0) spurious("done_spurious");
        else begin
          exp_done--;
          chk("done_latency", cyc - last_hs_cyc, 1);
        end
      end
    end
  end

  task automatic push_load(input logic [1:0] t, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      logic [ADDR_W-1:0] addr;
      beat_t b;
      addr = a + ADDR_W'(i) * 64'd256;
      exp_ar.push_back(addr);
      b.typ = t;
      b.cnt = CNT_W'(i);
      b.data = {4{addr}};
      exp_beat.push_back(b);
    end
    exp_done++;
  endtask

  task automatic issue(input logic [1:0] t, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] l);
    int n;
    @(negedge clk);
    tinst_valid = 1'b1; tinst_type = t; tinst_addr = a; tinst_len = l;
    n = 0;
    #3;
    while (!tinst_ready && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!tinst_ready) spurious("tinst_ready_timeout");
    @(negedge clk);
    tinst_valid = 1'b0; tinst_type = 2'd0; tinst_addr = '0; tinst_len = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      @(negedge clk);
      #3;
      if (done === 1'b1) got = 1'b1;
      n++;
    end
    chk(name, got, 1'b1);
    if (got) chk("ready_with_done", tinst_ready, 1'b1);
  endtask

  task automatic chk_queues_empty(input string name);
    chk({name, "_ar_q"}, exp_ar.size(), 0);
    chk({name, "_beat_q"}, exp_beat.size(), 0);
    chk({name, "_aw_q"}, exp_aw.size(), 0);
  endtask

  initial begin
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    aw_t w;
    int n;
    bit got;

    d0 = {4{64'hDEAD_BEEF_0000_0001}};
    d1 = {4{64'h0123_4567_89AB_CDEF}};
    d2 = {4{64'h5A5A_0F0F_C3C3_9696}};
    rst = 1'b1; tinst_valid = 1'b0; tinst_type = 2'd0; tinst_addr = '0; tinst_len = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_tinst_ready", tinst_ready, 1'b1);
    chk("rst_ar_valid", ar_valid, 1'b0);
    chk("rst_r_ready", r_ready, 1'b0);
    chk("rst_aw_valid", aw_valid, 1'b0);
    chk("rst_store_ready", store_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_abuf", abuf_id, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // PRELOADA 0x1000 len 3, free-flowing AR/R
    r_en = 1'b1;
    push_load(2'd1, 64'h1000, 6'd3);
    issue(2'd1, 64'h1000, 6'd3);
    chk("t1_abuf_toggle", abuf_id, 1'b1);
    chk("t1_busy", busy, 1'b1);
    wait_done("t1_done", 100);
    chk_queues_empty("t1");

    // TMMA len 15 with R held off: outstanding cap of 4
    r_en = 1'b0;
    ar_hs_cnt = 0;
    push_load(2'd0, 64'h2000, 6'd15);
    issue(2'd0, 64'h2000, 6'd15);
    repeat (12) @(negedge clk);
    #3;
    chk("t2_outstd_cap", ar_hs_cnt, 4);
    chk("t2_ar_stalled", ar_valid, 1'b0);
    chk("t2_abuf_hold", abuf_id, 1'b1);
    r_en = 1'b1;
    wait_done("t2_done", 200);
    chk("t2_ar_total", ar_hs_cnt, 16);
    chk_queues_empty("t2");

    // PRELOADC len 7: AR and R every cycle with two reads in flight
    r_en = 1'b0;
    ar_hs_cnt = 0;
    push_load(2'd2, 64'h3000, 6'd7);
    issue(2'd2, 64'h3000, 6'd7);
    n = 0;
    #3;
    while (ar_hs_cnt < 2 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("t3_two_ar", ar_hs_cnt, 2);
    r_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #3;
      chk("t3_outstd_steady", dut.outstd, 2);
    end
    wait_done("t3_done", 100);
    chk_queues_empty("t3");

    // STOREC at top of address space, len 1, toggling aw_ready
    st_q.push_back(d0);
    st_q.push_back(d1);
    w.addr = 64'hFFFF_FFFF_FFFF_FF00; w.data = d0; exp_aw.push_back(w);
    w.addr = 64'h0;                   w.data = d1; exp_aw.push_back(w);
    exp_done++;
    @(negedge clk);
    #3;
    chk("t4_aw_idle", aw_valid, 1'b0);
    aw_tog = 1'b1;
    issue(2'd3, 64'hFFFF_FFFF_FFFF_FF00, 6'd1);
    n = 0;
    got = 1'b0;
    #3;
    while (n < 50 && !got) begin
      if (busy) chk("t4_store_ready_mirror", store_ready, aw_ready);
      if (done === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        #3;
      end
      n++;
    end
    chk("t4_done", got, 1'b1);
    aw_tog = 1'b0;
    chk_queues_empty("t4");

    // PRELOADC full length (64 beats) with toggling ar_ready
    ar_tog = 1'b1;
    ar_hs_cnt = 0;
    push_load(2'd2, 64'h1_0000, 6'd63);
    issue(2'd2, 64'h1_0000, 6'd63);
    wait_done("t5_done", 600);
    chk("t5_ar_total", ar_hs_cnt, 64);
    ar_tog = 1'b0;
    chk_queues_empty("t5");

    // TMMA interrupted by reset after two beats
    beat_seen = 0;
    push_load(2'd0, 64'h8000, 6'd7);
    issue(2'd0, 64'h8000, 6'd7);
    n = 0;
    #3;
    while (beat_seen < 2 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("t6_two_beats", beat_seen >= 2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    force_rv = 1'b1;
    @(negedge clk);
    #3;
    rst = 1'b0;
    exp_ar.delete();
    exp_beat.delete();
    pend.delete();
    exp_done = 0;
    chk("t6_tinst_ready", tinst_ready, 1'b1);
    chk("t6_r_ready", r_ready, 1'b0);
    chk("t6_abuf_cleared", abuf_id, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_beat_valid", beat_valid, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #3;
      chk("t6_late_r_ignored", r_ready, 1'b0);
    end
    force_rv = 1'b0;

    // PRELOADA len 0: single AR/beat
    ar_hs_cnt = 0;
    push_load(2'd1, 64'h40, 6'd0);
    issue(2'd1, 64'h40, 6'd0);
    chk("t7_abuf_toggle", abuf_id, 1'b1);
    wait_done("t7_done", 50);
    chk("t7_ar_total", ar_hs_cnt, 1);
    chk_queues_empty("t7");

    // STOREC len 0: single AW
    st_q.push_back(d2);
    w.addr = 64'h500; w.data = d2; exp_aw.push_back(w);
    exp_done++;
    issue(2'd3, 64'h500, 6'd0);
    wait_done("t8_done", 50);
    chk_queues_empty("t8");
    repeat (3) @(negedge clk);
    chk("final_done_q", exp_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
